ram_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the shared 8-bit RAM (read/write/address/data/out interface).
- Port 0 is the instruction-fetch requester; port 1 is the data/load-store requester.
- Serialises requests, drives RAM command strobes as one-cycle pulses, captures read data after a fixed RAM latency and returns it to the granted port.
- Sits between the CPU control unit and the RAM.

---
 rtl/ram_arbiter.sv | 126 ++++++++++++
 tb/tb_ram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter/sequencer for the shared RAM
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module ram_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          ram_read,
  output logic          ram_write,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t     state;
  logic       rr_last;
  logic       cur;
  logic [2:0] cnt;
  logic       win;
  logic       win_we;

  always_comb begin
    win = req1;
    if (req0 && req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~rr_last;
`endif
    end
    win_we = win ? we1 : we0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_last   <= 1'b1;
      cur       <= 1'b0;
      cnt       <= 3'd0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
    end else begin
      // Strobes are single-cycle pulses; only the IDLE/WAIT branches raise them.
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            cur       <= win;
            rr_last   <= win;
            gnt0      <= ~win;
            gnt1      <= win;
            ram_addr  <= win ? addr1 : addr0;
            ram_data  <= win ? wdata1 : wdata0;
            ram_write <= win_we;
            ram_read  <= ~win_we;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ram_write) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt   <= 3'(RD_LAT);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 3'd1) begin
            if (cur) begin
              rdata1  <= ram_out;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= ram_out;
              rvalid0 <= 1'b1;
            end
            cnt   <= 3'd0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
// Honours RAM_ARB_FIXED_PRIO_EN when predicting tie-breaks.
module tb_ram_arbiter;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1, busy, ram_read, ram_write;
  logic [7:0] rdata0, rdata1, ram_addr, ram_data, ram_out;

  logic q_req0, q_we0;
  logic [7:0] q_addr0, q_wdata0;
  logic q_gnt0, q_gnt1, q_rv0, q_rv1, q_busy, q_ram_read, q_ram_write;
  logic [7:0] q_rd0, q_rd1, q_ram_addr, q_ram_data, q_ram_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(8), .DW(8), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy), .ram_read(ram_read),
    .ram_write(ram_write), .ram_addr(ram_addr), .ram_data(ram_data), .ram_out(ram_out)
  );

  ram_arbiter #(.AW(8), .DW(8), .RD_LAT(LAT3)) dut3 (
    .clk(clk), .rst(rst), .req0(q_req0), .req1(1'b0), .we0(q_we0), .we1(1'b0),
    .addr0(q_addr0), .addr1(8'h00), .wdata0(q_wdata0), .wdata1(8'h00),
    .gnt0(q_gnt0), .gnt1(q_gnt1), .rvalid0(q_rv0), .rvalid1(q_rv1),
    .rdata0(q_rd0), .rdata1(q_rd1), .busy(q_busy), .ram_read(q_ram_read),
    .ram_write(q_ram_write), .ram_addr(q_ram_addr), .ram_data(q_ram_data), .ram_out(q_ram_out)
  );

  // Bench RAMs: contents reload on rst; the RD_LAT=3 RAM shows garbage until its data is due.
  logic [7:0] mem [256];
  logic [7:0] mem3 [256];
  logic [7:0] rq_data;
  int rq_cnt;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      ram_out <= 8'h00;
    end else begin
      if (ram_write) mem[ram_addr] <= ram_data;
      if (ram_read) ram_out <= mem[ram_addr];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem3[i] <= 8'(i) ^ 8'h5A;
      q_ram_out <= 8'h00;
      rq_cnt <= 0;
      rq_data <= 8'h00;
    end else begin
      if (q_ram_write) mem3[q_ram_addr] <= q_ram_data;
      if (q_ram_read) begin
        rq_data   <= mem3[q_ram_addr];
        rq_cnt    <= LAT3 - 1;
        q_ram_out <= ~mem3[q_ram_addr];
      end else if (rq_cnt == 1) begin
        q_ram_out <= rq_data;
        rq_cnt    <= 0;
      end else if (rq_cnt > 1) begin
        rq_cnt <= rq_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] obs();
    return 64'({gnt1, gnt0, rvalid1, rvalid0, busy, ram_read, ram_write,
                ram_addr, ram_data, rdata0, rdata1});
  endfunction

  typedef struct {
    logic rst;
    logic r0, w0; logic [7:0] a0, d0;
    logic r1, w1; logic [7:0] a1, d1;
    logic [1:0] g, rv;
    logic bsy, rd, wr;
    logic [7:0] ad, dt, rd0, rd1;
  } vec_t;

  vec_t tbl [16];

  // Reference model state for the random phase
  logic [7:0] mm [256];
  int idle_at, rv_at;
  logic m_rr, rv_port;
  logic [7:0] rv_data, e_addr, e_data, e_rd0, e_rd1;
  logic act0, act1;
  int order [$];

  task automatic new_fields(output logic w, output logic [7:0] a, output logic [7:0] d);
    w = 1'($urandom_range(0, 1));
    a = 8'($urandom_range(0, 15));
    d = 8'($urandom);
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    q_req0 = 0; q_we0 = 0; q_addr0 = 0; q_wdata0 = 0;

    // Directed table: write, cross-port readback, reset, simultaneous requests
    tbl[0]  = '{T, F,F,8'h00,8'h00, F,F,8'h00,8'h00, 2'b00,2'b00, F,F,F, 8'h00,8'h00,8'h00,8'h00};
    tbl[1]  = '{F, T,T,8'h01,8'hAA, F,F,8'h00,8'h00, 2'b01,2'b00, T,F,T, 8'h01,8'hAA,8'h00,8'h00};
    tbl[2]  = '{F, F,F,8'h01,8'hAA, F,F,8'h00,8'h00, 2'b00,2'b00, F,F,F, 8'h01,8'hAA,8'h00,8'h00};
    tbl[3]  = '{F, F,F,8'h00,8'h00, T,F,8'h01,8'h00, 2'b10,2'b00, T,T,F, 8'h01,8'h00,8'h00,8'h00};
    tbl[4]  = '{F, F,F,8'h00,8'h00, F,F,8'h01,8'h00, 2'b00,2'b00, T,F,F, 8'h01,8'h00,8'h00,8'h00};
    tbl[5]  = '{F, F,F,8'h00,8'h00, F,F,8'h01,8'h00, 2'b00,2'b10, F,F,F, 8'h01,8'h00,8'h00,8'hAA};
    tbl[6]  = '{F, F,F,8'h00,8'h00, F,F,8'h01,8'h00, 2'b00,2'b00, F,F,F, 8'h01,8'h00,8'h00,8'hAA};
    tbl[7]  = '{T, F,F,8'h00,8'h00, F,F,8'h00,8'h00, 2'b00,2'b00, F,F,F, 8'h00,8'h00,8'h00,8'h00};
    tbl[8]  = '{F, T,T,8'h0A,8'hCC, T,F,8'h1F,8'h00, 2'b01,2'b00, T,F,T, 8'h0A,8'hCC,8'h00,8'h00};
    tbl[9]  = '{F, F,F,8'h0A,8'hCC, T,F,8'h1F,8'h00, 2'b00,2'b00, F,F,F, 8'h0A,8'hCC,8'h00,8'h00};
    tbl[10] = '{F, F,F,8'h0A,8'hCC, T,F,8'h1F,8'h00, 2'b10,2'b00, T,T,F, 8'h1F,8'h00,8'h00,8'h00};
    tbl[11] = '{F, F,F,8'h0A,8'hCC, F,F,8'h1F,8'h00, 2'b00,2'b00, T,F,F, 8'h1F,8'h00,8'h00,8'h00};
    tbl[12] = '{F, F,F,8'h0A,8'hCC, F,F,8'h1F,8'h00, 2'b00,2'b10, F,F,F, 8'h1F,8'h00,8'h00,8'h45};
    tbl[13] = '{F, T,F,8'h0A,8'h00, F,F,8'h00,8'h00, 2'b01,2'b00, T,T,F, 8'h0A,8'h00,8'h00,8'h45};
    tbl[14] = '{F, F,F,8'h0A,8'h00, F,F,8'h00,8'h00, 2'b00,2'b00, T,F,F, 8'h0A,8'h00,8'h00,8'h45};
    tbl[15] = '{F, F,F,8'h0A,8'h00, F,F,8'h00,8'h00, 2'b00,2'b01, F,F,F, 8'h0A,8'h00,8'hCC,8'h45};

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst;
      req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("table[%0d]", i), obs(),
          64'({tbl[i].g, tbl[i].rv, tbl[i].bsy, tbl[i].rd, tbl[i].wr,
               tbl[i].ad, tbl[i].dt, tbl[i].rd0, tbl[i].rd1}));
    end

    // Fairness: both ports held high for eight grants
    rst = 1; idle_inputs();
    @(negedge clk);
    rst = 0;
    req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 8'h11;
    req1 = 1; we1 = 1; addr1 = 8'h31; wdata1 = 8'h22;
    for (int k = 0; k < 40 && order.size() < 8; k++) begin
      @(negedge clk);
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
    idle_inputs();
    chk("fair_count", 64'(order.size()), 64'd8);
    for (int i = 0; i < order.size(); i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      chk($sformatf("fair_order[%0d]", i), 64'(order[i]), 64'd0);
`else
      chk($sformatf("fair_order[%0d]", i), 64'(order[i]), 64'(i % 2));
`endif
    end
    @(negedge clk);
    @(negedge clk);

    // Reset while a port-0 read is in WAIT
    begin
      int rv0_seen, rv1_seen;
      req0 = 1; we0 = 0; addr0 = 8'h02;
      @(negedge clk);
      chk("rw_gnt0", 64'(gnt0), 64'd1);
      req0 = 0;
      @(negedge clk);
      chk("rw_wait_busy", 64'(busy), 64'd1);
      rst = 1;
      @(negedge clk);
      chk("rw_reset_zero", obs(), 64'd0);
      rst = 0;
      req1 = 1; we1 = 0; addr1 = 8'h1F;
      @(negedge clk);
      chk("rw_gnt1", 64'({gnt1, gnt0, rvalid0}), 64'b100);
      req1 = 0;
      rv0_seen = 0; rv1_seen = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        rv0_seen += int'(rvalid0);
        rv1_seen += int'(rvalid1);
      end
      chk("rw_no_rvalid0", 64'(rv0_seen), 64'd0);
      chk("rw_rvalid1_once", 64'(rv1_seen), 64'd1);
      chk("rw_rdata1", 64'(rdata1), 64'h45);
    end

    // RD_LAT = 3 instance: rvalid exactly four cycles after the gnt cycle
    begin
      int lat_seen;
      q_req0 = 1; q_we0 = 1; q_addr0 = 8'h01; q_wdata0 = 8'hAA;
      @(negedge clk);
      chk("l3_wr_gnt", 64'(q_gnt0), 64'd1);
      q_req0 = 0;
      @(negedge clk);
      q_req0 = 1; q_we0 = 0;
      @(negedge clk);
      chk("l3_rd_gnt", 64'({q_gnt0, q_busy, q_ram_read}), 64'b111);
      q_req0 = 0;
      lat_seen = 0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (q_rv0 && lat_seen == 0) lat_seen = k;
      end
      chk("l3_latency", 64'(lat_seen), 64'd4);
      chk("l3_rdata", 64'(q_rd0), 64'hAA);
      chk("l3_port1_quiet", 64'({q_gnt1, q_rv1, q_rd1}), 64'd0);
    end

    // Random traffic against a transaction-level timing model
    rst = 1; idle_inputs();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 256; i++) mm[i] = 8'(i) ^ 8'h5A;
    idle_at = 0; rv_at = -1; m_rr = 1; rv_port = 0; rv_data = 0;
    e_addr = 0; e_data = 0; e_rd0 = 0; e_rd1 = 0;
    act0 = 0; act1 = 0;
    for (int n = 0; n < 600; n++) begin
      logic [1:0] e_g, e_rv;
      logic e_rd, e_wr, e_busy, w, we_w;
      logic [7:0] a_w, d_w;
      @(negedge clk);
      e_g = 0; e_rv = 0; e_rd = 0; e_wr = 0;
      if (rv_at == n) begin
        e_rv[rv_port] = 1'b1;
        if (rv_port) e_rd1 = rv_data; else e_rd0 = rv_data;
      end
      if (n >= idle_at && (req0 || req1)) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        w = req1 && !req0;
`else
        w = (req0 && req1) ? !m_rr : (req1 && !req0);
`endif
        m_rr = w;
        e_g[w] = 1'b1;
        we_w = w ? we1 : we0;
        a_w  = w ? addr1 : addr0;
        d_w  = w ? wdata1 : wdata0;
        e_addr = a_w; e_data = d_w;
        e_wr = we_w; e_rd = !we_w;
        if (we_w) begin
          mm[a_w] = d_w;
          idle_at = n + 2;
        end else begin
          rv_at = n + 1 + LAT;
          rv_port = w;
          rv_data = mm[a_w];
          idle_at = n + 2 + LAT;
        end
      end
      e_busy = (n + 2 <= idle_at);
      chk($sformatf("rand[%0d]", n), obs(),
          64'({e_g, e_rv, e_busy, e_rd, e_wr, e_addr, e_data, e_rd0, e_rd1}));
      if (act0 && e_g[0]) begin
        act0 = 1'($urandom_range(0, 1));
        if (act0) new_fields(we0, addr0, wdata0);
      end else if (!act0) begin
        act0 = ($urandom_range(0, 2) == 0);
        if (act0) new_fields(we0, addr0, wdata0);
      end
      if (act1 && e_g[1]) begin
        act1 = 1'($urandom_range(0, 1));
        if (act1) new_fields(we1, addr1, wdata1);
      end else if (!act1) begin
        act1 = ($urandom_range(0, 2) == 0);
        if (act1) new_fields(we1, addr1, wdata1);
      end
      req0 = act0;
      req1 = act1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
